// File: rtl/program_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | program_sequencer: program RAM plus in-order issue to a control unit     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module program_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_wdata,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              cu_done,
  output logic [15:0]       instr_out,
  output logic              run_out,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              finished,
  output logic              error
);

  localparam int                 DEPTH    = 1 << ADDR_W;
  localparam int                 TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);
  localparam logic [ADDR_W:0]    LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0]  PC_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W:0]   len;
  logic [TMR_W-1:0]  timer;
  logic              zero_fin;
  logic              last_instr;
  logic              timed_out;
  logic              start_ok;

  assign last_instr = ({1'b0, pc} == (len - LEN_ONE));
  assign timed_out  = (timer == TMR_LAST);
  assign start_ok   = start && (prog_len != '0);

  // Program RAM is deliberately left out of reset so a program survives it.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_ok) state_next = S_FETCH;
      S_FETCH: state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (cu_done) begin
          state_next = last_instr ? S_DONE : S_FETCH;
        end else if (timed_out) begin
          state_next = S_IDLE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc        <= '0;
      instr_out <= '0;
      error     <= 1'b0;
      timer     <= '0;
      len       <= '0;
      zero_fin  <= 1'b0;
    end else begin
      zero_fin <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (prog_len != '0) begin
              len <= prog_len;
              pc  <= '0;
            end else begin
              zero_fin <= 1'b1;
            end
          end
        end
        S_FETCH: instr_out <= mem[pc];
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          timer <= timer + TMR_ONE;
          // Abort wins over both completion and timeout.
          if (!abort) begin
            if (cu_done) begin
              if (!last_instr) pc <= pc + PC_ONE;
            end else if (timed_out) begin
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign run_out  = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);
  assign finished = ((state == S_DONE) && !abort) || zero_fin;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// Directed bench for program_sequencer with an issue-order scoreboard.
module tb_program_sequencer;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [4:0]  prog_len;
  logic        start;
  logic        abort;
  logic        cu_done = 1'b0;
  logic [15:0] instr_out;
  logic        run_out;
  logic [3:0]  pc;
  logic        busy;
  logic        finished;
  logic        error;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  exp_t sb_q[$];
  exp_t e;
  logic [15:0] model [16];

  int cu_delay = 0;
  int cnt = 0;
  int run_cnt = 0;
  int fin_cnt = 0;
  int fin_cyc = 0;
  int err_cyc = 0;
  int last_run = 0;
  logic prev_err = 1'b0;
  logic spacing_on = 1'b0;
  int spacing_base = 0;

  int base_run;
  int base_fin;

  program_sequencer #(.ADDR_W(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .prog_len   (prog_len),
    .start      (start),
    .abort      (abort),
    .cu_done    (cu_done),
    .instr_out  (instr_out),
    .run_out    (run_out),
    .pc         (pc),
    .busy       (busy),
    .finished   (finished),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control-unit model plus scoreboard pop; cu_done changes on the falling edge.
  always @(negedge clk) begin
    cu_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) cu_done = 1'b1;
    end
    if (finished) begin
      fin_cnt++;
      fin_cyc = cycle;
    end
    if (error && !prev_err) err_cyc = cycle;
    prev_err = error;
    if (run_out) begin
      run_cnt++;
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("instr_out", instr_out, e.instr);
        check("pc", pc, e.pc);
      end
      if (spacing_on && (run_cnt - spacing_base) >= 2) check("run_spacing", cycle - last_run, 3);
      last_run = cycle;
      if (cu_delay > 0) cnt = cu_delay;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    cyc();
    prog_we = 1'b0;
    model[a] = d;
  endtask

  task automatic run_prog(input int len, input int n_issue);
    for (int i = 0; i < n_issue; i++) sb_q.push_back('{instr: model[i], pc: 4'(i)});
    prog_len = 5'(len);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cyc();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic snap();
    base_run = run_cnt;
    base_fin = fin_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    prog_len = '0; start = 1'b0; abort = 1'b0;
    cyc(); cyc();
    check("rst_busy", busy, 0);
    check("rst_run", run_out, 0);
    check("rst_pc", pc, 0);
    check("rst_instr", instr_out, 0);
    check("rst_fin", finished, 0);
    check("rst_err", error, 0);
    reset_n = 1'b1;
    cyc();

    // Three-instruction program, cu_done two cycles after each issue
    write_word(4'd0, 16'h2008);
    write_word(4'd1, 16'h4410);
    write_word(4'd2, 16'h6C3C);
    cu_delay = 2;
    snap();
    run_prog(3, 3);
    wait_idle(100, "t1_idle");
    check("t1_runs", run_cnt - base_run, 3);
    check("t1_fins", fin_cnt - base_fin, 1);
    check("t1_busy_low_after_fin", cycle - fin_cyc, 1);
    check("t1_sb_empty", sb_q.size(), 0);
    check("t1_err", error, 0);

    // Zero-length program
    snap();
    run_prog(0, 0);
    check("t2_fin_pulse", finished, 1);
    check("t2_busy", busy, 0);
    cyc();
    check("t2_fin_low", finished, 0);
    check("t2_busy2", busy, 0);
    check("t2_fins", fin_cnt - base_fin, 1);
    check("t2_runs", run_cnt - base_run, 0);

    // Hung control unit: 16 WAIT cycles, then error on the following edge
    cu_delay = 0;
    snap();
    run_prog(2, 1);
    wait_idle(60, "t3_idle");
    check("t3_err", error, 1);
    check("t3_err_delay", err_cyc - last_run, 17);
    check("t3_fins", fin_cnt - base_fin, 0);
    check("t3_runs", run_cnt - base_run, 1);
    check("t3_sb_empty", sb_q.size(), 0);
    cu_delay = 1;
    snap();
    run_prog(2, 2);
    check("t3_err_cleared", error, 0);
    wait_idle(60, "t3b_idle");
    check("t3b_fins", fin_cnt - base_fin, 1);

    // Abort in WAIT of the second instruction
    write_word(4'd3, 16'h8A5F);
    cu_delay = 3;
    snap();
    run_prog(4, 2);
    begin
      int n;
      n = 0;
      while ((run_cnt - base_run) < 2 && n < 50) begin
        cyc();
        n++;
      end
      check("t4_reached_second_issue", run_cnt - base_run, 2);
    end
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_run", run_out, 0);
    repeat (6) cyc();
    check("t4_runs", run_cnt - base_run, 2);
    check("t4_fins", fin_cnt - base_fin, 0);
    check("t4_sb_empty", sb_q.size(), 0);
    check("t4_err", error, 0);

    // RAM write while busy must be dropped
    cu_delay = 2;
    snap();
    run_prog(4, 4);
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 16'hFFFF;
    cyc();
    prog_we = 1'b0;
    wait_idle(100, "t4b_idle");
    check("t4b_fins", fin_cnt - base_fin, 1);
    snap();
    run_prog(1, 1);
    wait_idle(40, "t4c_idle");
    check("t4c_runs", run_cnt - base_run, 1);
    check("t4c_sb_empty", sb_q.size(), 0);

    // Full RAM with immediate cu_done
    for (int i = 0; i < 16; i++) write_word(4'(i), 16'(i * 16'h0F1D + 16'h0123));
    cu_delay = 1;
    spacing_base = run_cnt;
    spacing_on = 1'b1;
    snap();
    run_prog(16, 16);
    wait_idle(200, "t5_idle");
    spacing_on = 1'b0;
    check("t5_runs", run_cnt - base_run, 16);
    check("t5_fins", fin_cnt - base_fin, 1);
    check("t5_pc_last", pc, 15);
    check("t5_sb_empty", sb_q.size(), 0);

    // Reset while in ISSUE
    cu_delay = 2;
    snap();
    run_prog(3, 1);
    cyc();
    reset_n = 1'b0;
    cyc();
    check("t6_busy", busy, 0);
    check("t6_run", run_out, 0);
    check("t6_pc", pc, 0);
    check("t6_instr", instr_out, 0);
    check("t6_fin", finished, 0);
    check("t6_err", error, 0);
    reset_n = 1'b1;
    repeat (4) cyc();
    snap();
    run_prog(3, 3);
    wait_idle(100, "t6b_idle");
    check("t6b_runs", run_cnt - base_run, 3);
    check("t6b_fins", fin_cnt - base_fin, 1);
    check("t6b_sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
